// File: rtl/hamming_pkg.sv
// Shared constants, FSM encoding and data-extraction map for the Hamming(15,11) receive path.
package hamming_pkg;

  localparam int CW_W   = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Codeword bit j (1-based) sits at cw[j-1]; parity occupies j = 1, 2, 4, 8.
  // The remaining positions carry the 11 data bits, highest position last.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[2], cw[6:4], cw[14:8]};
  endfunction

endpackage

// File: rtl/hamming15_syndrome.sv
// Combinational 4-bit syndrome of a 15-bit Hamming codeword (detection only).
module hamming15_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [SYN_W-1:0] syndrome
);

  // Syndrome bit k is the XOR of every codeword position whose 1-based index has bit k set.
  always_comb begin
    syndrome = '0;
    for (int j = 1; j <= CW_W; j++) begin
      for (int k = 0; k < SYN_W; k++) begin
        if (((j >> k) & 1) != 0) syndrome[k] = syndrome[k] ^ cw[j-1];
      end
    end
  end

endmodule

// File: rtl/hamming_rx_arbiter.sv
// Round-robin arbiter sharing one Hamming(15,11) check stage between NUM_REQ requesters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a requester; grant issued combinationally here
//   ST_CHECK | latched codeword is checked; results registered on exit
//   ST_OUT   | result presented, held until the consumer accepts it
module hamming_rx_arbiter
  import hamming_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ERR_CNT_W = 8,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [CW_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    out_err,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic                    busy
);

  state_t            state, state_nxt;
  logic [SRC_W-1:0]  rr_ptr, winner, ptr_after, src_reg;
  logic              found, grant, syn_err;
  int                cand, win_i;
  logic [CW_W-1:0]   cw_reg;
  logic [SYN_W-1:0]  syndrome;
  logic [CW_W-1:0]   req_cw [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_cw[g] = req_data[g*CW_W +: CW_W];
  end

  hamming15_syndrome u_syndrome (
    .cw       (cw_reg),
    .syndrome (syndrome)
  );

  assign syn_err   = |syndrome;
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

  // Round-robin search from rr_ptr; scanning backwards lets the nearest valid requester win.
  always_comb begin
    found = 1'b0;
    cand  = 0;
    win_i = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (req_valid[SRC_W'(cand)]) begin
        found = 1'b1;
        win_i = cand;
      end
    end
    winner    = SRC_W'(win_i);
    ptr_after = SRC_W'((win_i + 1) % NUM_REQ);
  end

  // Next-state and grant decode; reset suppresses any grant in the same cycle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_nxt         = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      req_ready = '0;
      grant     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Grant capture, result registers and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cw_reg    <= '0;
      src_reg   <= '0;
      out_data  <= '0;
      out_src   <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (grant) begin
        cw_reg  <= req_cw[winner];
        src_reg <= winner;
        rr_ptr  <= ptr_after;
      end
      if (state == ST_CHECK) begin
        out_err  <= syn_err;
        out_data <= syn_err ? '0 : extract_data(cw_reg);
        out_src  <= src_reg;
        if (syn_err && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule
